parity_frame_ctrl: RTL and testbench
====================================

Name: parity_frame_ctrl

Overview:
Frame sequencer for the byte-parity datapath. On a start pulse it accepts exactly FRAME_LEN bytes over a valid/ready input, and forwards each byte with its parity bit. It then appends one longitudinal-parity trailer byte, the XOR of all frame bytes. It sits between the byte stimulus/source and the downstream parity consumer and owns frame boundaries and flow control.

Parameters:
FRAME_LEN, 4, data bytes per frame; legal range 1..255.
ODD_PARITY, 0, 0 gives even parity (par = ^byte); 1 gives odd parity (par = ~^byte).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous and active-high; clears all state.
start  in  1  begin frame; sampled only in IDLE.
in_valid  in  1  data_in holds a valid byte.
in_ready  out  1  block accepts data_in this cycle.
data_in  in  8  frame byte.
out_valid  out  1  data_out/par_out/out_last are valid.
out_ready  in  1  downstream accepts output this cycle.
data_out  out  8  forwarded byte or trailer byte.
par_out  out  1  parity of data_out per ODD_PARITY.
out_last  out  1  high with the trailer byte only.
busy  out  1  state != IDLE.
frame_cnt  out  8  count of completed frames; wraps 255->0.

Behaviour:
- Reset values: in_ready=0, out_valid=0, data_out=0, par_out=0, out_last=0, busy=0, frame_cnt=0. The internal lrc accumulator and byte counter are also 0, and the state is IDLE.
- Output stage is a single register slot. The slot is free when !out_valid || out_ready.
- States: IDLE, DATA, TRAILER, FLUSH.
- IDLE:
  - in_ready=0.
  - start=1 moves to DATA next cycle and clears lrc and the byte counter.
- DATA:
  - in_ready = slot free.
  - Input handshake (in_valid && in_ready) registers data_out<=data_in, par_out<=^data_in^ODD_PARITY, out_last<=0 and out_valid<=1.
  - The same handshake updates lrc<=lrc^data_in and increments the byte counter.
  - Handshake on byte FRAME_LEN moves to TRAILER.
- TRAILER:
  - in_ready=0.
  - When the slot is free, loads data_out<=lrc, par_out<=^lrc^ODD_PARITY, out_last<=1, out_valid<=1, then moves to FLUSH.
- FLUSH:
  - in_ready=0.
  - On output handshake of the trailer: out_valid<=0, frame_cnt<=frame_cnt+1, then IDLE.
- Output handshake with no new load clears out_valid.
- Output register holds its value while out_valid && !out_ready; no data is dropped or duplicated.
- Timing and latency:
  - Input-to-output latency is 1 cycle.
  - With in_valid=1 and out_ready=1 held, a frame occupies FRAME_LEN+1 consecutive out_valid cycles with no bubble. The trailer follows the last data byte directly.
- start while busy is ignored. start held high in IDLE after frame completion begins a new frame immediately.
- in_valid in IDLE/TRAILER/FLUSH is ignored; no byte is consumed.
- Reset asserted mid-frame discards the partial frame. Outputs return to reset values immediately (asynchronously). frame_cnt is not incremented.
- frame_cnt increments only on trailer handshake, modulo 256.

Optional Feature:
PARITY_FRAME_CHECK_EN
- Defined:
  - Adds input par_in (1 bit, valid with data_in) and output par_err (1 bit, sticky, reset 0).
  - On each accepted byte, if par_in != parity(data_in), par_err<=1.
  - par_err clears on the next start accepted in IDLE.
  - Parity checking is not applied to the trailer; it has no input.
- Undefined: ports par_in/par_err do not exist and no check logic is built; all other behaviour is identical.

Test Plan:
- Even parity, FRAME_LEN=4, out_ready=1, bytes 0x04,0xBD,0x64,0xFF back-to-back -> outputs 0x04/p1, 0xBD/p0, 0x64/p1, 0xFF/p0, then 0x22/p0 with out_last=1 on 5 consecutive cycles; frame_cnt 0->1.
- Same bytes with ODD_PARITY=1 -> parities 0,1,0,1; trailer 0x22 with par_out=1.
- out_ready low for 3 cycles while holding 0xBD -> data_out stays 0xBD, in_ready=0, no byte lost; 0x64 accepted the cycle after out_ready returns.
- rst pulsed after 2 of 4 bytes -> all outputs 0 immediately, frame_cnt stays 0; a new start with 0x01,0x02,0x03,0x04 yields trailer 0x04 (lrc restarted).
- start pulses during DATA and FLUSH, and in_valid=1 in IDLE -> no new frame, no byte consumed; 256 completed frames -> frame_cnt wraps to 0.
- PARITY_FRAME_CHECK_EN: 0x04 sent with par_in=0 -> par_err=1 and stays set through the trailer; next start clears it to 0.

Source files
------------

// File: rtl/parity_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | parity_frame_ctrl : frames FRAME_LEN bytes with per-byte parity plus an  |
// | LRC trailer. Optional input-parity check: PARITY_FRAME_CHECK_EN.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module parity_frame_ctrl #(
  parameter int FRAME_LEN  = 4,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] data_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] data_out,
  output logic       par_out,
  output logic       out_last,
  output logic       busy,
  output logic [7:0] frame_cnt
`ifdef PARITY_FRAME_CHECK_EN
  ,
  input  logic       par_in,
  output logic       par_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DATA    = 2'd1,
    S_TRAILER = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  localparam logic       c_odd      = ODD_PARITY;
  localparam logic [7:0] c_last_idx = 8'(FRAME_LEN - 1);

  state_t     r_state;
  logic [7:0] r_lrc;
  logic [7:0] r_cnt;

  logic w_slot_free;
  logic w_out_hs;
  logic w_in_hs;
  logic w_in_par;
  logic w_lrc_par;

  // The output register is the only buffer: it may be refilled in the same
  // cycle its current content is taken downstream.
  assign w_slot_free = !out_valid || out_ready;
  assign w_out_hs    = out_valid && out_ready;
  assign in_ready    = (r_state == S_DATA) && w_slot_free;
  assign w_in_hs     = in_valid && in_ready;
  assign w_in_par    = (^data_in) ^ c_odd;
  assign w_lrc_par   = (^r_lrc) ^ c_odd;
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lrc     <= 8'd0;
      r_cnt     <= 8'd0;
      out_valid <= 1'b0;
      data_out  <= 8'd0;
      par_out   <= 1'b0;
      out_last  <= 1'b0;
      frame_cnt <= 8'd0;
`ifdef PARITY_FRAME_CHECK_EN
      par_err   <= 1'b0;
`endif
    end else begin
      // A taken beat empties the slot unless a load below refills it.
      if (w_out_hs) begin
        out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_DATA;
            r_lrc   <= 8'd0;
            r_cnt   <= 8'd0;
`ifdef PARITY_FRAME_CHECK_EN
            par_err <= 1'b0;
`endif
          end
        end

        S_DATA: begin
          if (w_in_hs) begin
            data_out  <= data_in;
            par_out   <= w_in_par;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            r_lrc     <= r_lrc ^ data_in;
            r_cnt     <= r_cnt + 8'd1;
`ifdef PARITY_FRAME_CHECK_EN
            if (par_in != w_in_par) begin
              par_err <= 1'b1;
            end
`endif
            if (r_cnt == c_last_idx) begin
              r_state <= S_TRAILER;
            end
          end
        end

        S_TRAILER: begin
          if (w_slot_free) begin
            data_out  <= r_lrc;
            par_out   <= w_lrc_par;
            out_last  <= 1'b1;
            out_valid <= 1'b1;
            r_state   <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          if (w_out_hs) begin
            frame_cnt <= frame_cnt + 8'd1;
            r_state   <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_parity_frame_ctrl : random and directed frames for parity_frame_ctrl  |
// | against a queue-based output-stream model. Rev 1.0                      |
// +--------------------------------------------------------------------------+
module tb_parity_frame_ctrl;

  localparam int FLEN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] data_in;

  logic       ir_e, ov_e, par_e, last_e, busy_e;
  logic [7:0] do_e, fc_e;
  logic       ir_o, ov_o, par_o, last_o, busy_o;
  logic [7:0] do_o, fc_o;
`ifdef PARITY_FRAME_CHECK_EN
  logic       par_in;
  logic       par_in_o;
  logic       perr_e, perr_o;
  assign par_in_o = ~par_in;
`endif

  always #5 clk = ~clk;

  parity_frame_ctrl #(.FRAME_LEN(FLEN), .ODD_PARITY(1'b0)) dut_e (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ir_e),
    .data_in(data_in), .out_valid(ov_e), .out_ready(out_ready), .data_out(do_e),
    .par_out(par_e), .out_last(last_e), .busy(busy_e), .frame_cnt(fc_e)
`ifdef PARITY_FRAME_CHECK_EN
    , .par_in(par_in), .par_err(perr_e)
`endif
  );

  parity_frame_ctrl #(.FRAME_LEN(FLEN), .ODD_PARITY(1'b1)) dut_o (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ir_o),
    .data_in(data_in), .out_valid(ov_o), .out_ready(out_ready), .data_out(do_o),
    .par_out(par_o), .out_last(last_o), .busy(busy_o), .frame_cnt(fc_o)
`ifdef PARITY_FRAME_CHECK_EN
    , .par_in(par_in_o), .par_err(perr_o)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic even_par(input logic [7:0] b);
    return 1'($countones(b) % 2);
  endfunction

  // Model: ordered list of beats the block owes downstream.
  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } beat_t;

  beat_t      q[$];
  bit         m_busy, m_taking, m_perr;
  int         m_n, m_frames;
  logic [7:0] m_lrc;
  logic [7:0] last_trailer;
  int         run_len, last_run;
  logic [7:0] fb [0:FLEN-1];

  always @(negedge clk) begin
    bit exp_ir, out_hs;
    if (rst) begin
      q.delete();
      m_busy = 0; m_taking = 0; m_perr = 0; m_n = 0; m_frames = 0; m_lrc = 8'd0;
      run_len = 0;
    end else begin
      exp_ir = m_taking && (q.size() == 0 || out_ready);
      out_hs = (q.size() > 0) && out_ready;
      chk("out_valid", ov_e, q.size() > 0);
      chk("out_valid_odd", ov_o, q.size() > 0);
      if (q.size() > 0) begin
        chk("data_out", do_e, q[0].d);
        chk("data_out_odd", do_o, q[0].d);
        chk("par_even", par_e, even_par(q[0].d));
        chk("par_odd", par_o, !even_par(q[0].d));
        chk("out_last", last_e, q[0].last);
        chk("out_last_odd", last_o, q[0].last);
      end
      chk("busy", busy_e, m_busy);
      chk("in_ready", ir_e, exp_ir);
      chk("in_ready_odd", ir_o, exp_ir);
      chk("frame_cnt", fc_e, m_frames % 256);
      chk("frame_cnt_odd", fc_o, m_frames % 256);
`ifdef PARITY_FRAME_CHECK_EN
      chk("par_err", perr_e, m_perr);
      chk("par_err_odd", perr_o, m_perr);
`endif
      if (ov_e) run_len++;
      else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
      if (start && !m_busy) begin
        m_busy = 1; m_taking = 1; m_n = 0; m_lrc = 8'd0; m_perr = 0;
      end
      if (out_hs) begin
        if (q[0].last) begin
          m_busy = 0;
          m_frames++;
          last_trailer = q[0].d;
        end
        void'(q.pop_front());
      end
      if (in_valid && exp_ir) begin
        q.push_back({data_in, 1'b0});
        m_lrc = m_lrc ^ data_in;
        m_n++;
`ifdef PARITY_FRAME_CHECK_EN
        if (par_in != even_par(data_in)) m_perr = 1;
`endif
        if (m_n == FLEN) begin
          q.push_back({m_lrc, 1'b1});
          m_taking = 0;
        end
      end
    end
  end

  // Called at posedge+1 with the block idle; sends fb[] as one frame.
  task automatic run_frame(input int vprob, input bit rrand, input int stall_at,
                           input bit poke, input int bad_idx);
    int i = 0;
    int guard = 0;
    int stall = 0;
    bit res_pend = 0;
    bit stalled, resume, hs;
    start = 1; in_valid = 0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 0;
    while (i < FLEN && guard < 400) begin
      guard++;
      stalled = 0; resume = 0;
      if (stall > 0) begin
        out_ready = 1'b0; stall--; stalled = 1;
        if (stall == 0) res_pend = 1;
      end else begin
        out_ready = rrand ? ($urandom_range(3) != 0) : 1'b1;
        resume = res_pend; res_pend = 0;
      end
      in_valid = (vprob >= 100) || ($urandom_range(99) < vprob) || resume;
      data_in  = fb[i];
`ifdef PARITY_FRAME_CHECK_EN
      par_in   = even_par(fb[i]) ^ (i == bad_idx);
`endif
      start    = poke && (i == 2);
      @(negedge clk);
      if (stalled) begin
        chk("stall_hold", do_e, fb[i-1]);
        chk("stall_in_ready", ir_e, 1'b0);
      end
      if (resume) chk("stall_resume", ir_e, 1'b1);
      hs = in_valid && ir_e;
      @(posedge clk); #1;
      if (hs) begin
        i++;
        if (i == stall_at + 1) stall = 3;
      end
    end
    in_valid = 0; start = 0;
    if (guard >= 400) chk("feed_timeout", i, FLEN);
    guard = 0;
    while (busy_e && guard < 100) begin
      out_ready = rrand ? ($urandom_range(3) != 0) : 1'b1;
      start = poke;
      @(posedge clk); #1;
      guard++;
    end
    start = 0; out_ready = 1'b1;
    chk("drain_timeout", busy_e, 1'b0);
  endtask

  task automatic idle_noise(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid  = 1'($urandom_range(1));
      data_in   = 8'($urandom);
      out_ready = 1'($urandom_range(1));
      start     = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1'b1;
  endtask

  task automatic set_fb(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
    fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3;
  endtask

  task automatic rand_fb();
    for (int k = 0; k < FLEN; k++) fb[k] = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 0; in_valid = 0; out_ready = 1'b1; data_in = 8'd0;
`ifdef PARITY_FRAME_CHECK_EN
    par_in = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov_e, 1'b0);
    chk("rst_in_ready", ir_e, 1'b0);
    chk("rst_data_out", do_e, 8'd0);
    chk("rst_busy", busy_e, 1'b0);
    chk("rst_frame_cnt", fc_e, 8'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Test-plan bytes at full rate: 5-beat burst, trailer 0x22.
    set_fb(8'h04, 8'hBD, 8'h64, 8'hFF);
    run_frame(100, 0, -1, 0, -1);
    @(negedge clk); #1;
    chk("burst_len", last_run, FLEN + 1);
    chk("trailer_22", last_trailer, 8'h22);
    chk("frame_cnt_1", fc_e, 8'd1);

    // Downstream stall of 3 cycles while 0xBD is held.
    idle_noise(3);
    run_frame(100, 0, 1, 1, -1);

    // Reset mid-frame after 2 bytes.
    set_fb(8'h11, 8'h22, 8'h33, 8'h44);
    start = 1;
    @(posedge clk); #1;
    start = 0; in_valid = 1; data_in = fb[0];
    @(posedge clk); #1;
    data_in = fb[1];
    @(posedge clk); #1;
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", ov_e, 1'b0);
    chk("arst_data_out", do_e, 8'd0);
    chk("arst_par_out", par_o, 1'b0);
    chk("arst_busy", busy_e, 1'b0);
    chk("arst_frame_cnt", fc_e, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    set_fb(8'h01, 8'h02, 8'h03, 8'h04);
    run_frame(100, 0, -1, 0, -1);
    chk("lrc_restart", last_trailer, 8'h04);

`ifdef PARITY_FRAME_CHECK_EN
    set_fb(8'h04, 8'hBD, 8'h64, 8'hFF);
    run_frame(100, 0, -1, 0, 0);
    chk("par_err_sticky", perr_e, 1'b1);
    run_frame(100, 0, -1, 0, -1);
    chk("par_err_cleared", perr_e, 1'b0);
`endif

    // Bring the count since reset to 256 frames.
    while (m_frames < 256) begin
      rand_fb();
      run_frame(100, 0, -1, 0, -1);
    end
    chk("frame_cnt_wrap", fc_e, 8'd0);

    for (int f = 0; f < 40; f++) begin
      rand_fb();
      idle_noise($urandom_range(3));
      run_frame($urandom_range(100, 30), 1, -1, 1'($urandom_range(1)), -1);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
